// File: rtl/load_writeback_pkg.sv
// load_writeback_pkg: load funct3 encodings shared with the decoder
package load_writeback_pkg;
  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
endpackage

// File: rtl/load_writeback_if.sv
// load_writeback_if: issue, RAM response, hazard check and write-back signals
interface load_writeback_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
);
  logic issue_valid;
  logic issue_ready;
  logic [ADDR_WIDTH-1:0] issue_rd;
  logic [2:0] issue_funct3;
  logic [1:0] issue_offset;
  logic resp_valid;
  logic [WIDTH-1:0] resp_data;
  logic [ADDR_WIDTH-1:0] chk_rs1;
  logic [ADDR_WIDTH-1:0] chk_rs2;
  logic [ADDR_WIDTH-1:0] chk_rd;
  logic stall;
  logic [ADDR_WIDTH-1:0] ra3;
  logic [WIDTH-1:0] wd3;
  logic we3;
  logic [$clog2(DEPTH):0] pending;
  modport master(
    output issue_valid, issue_rd, issue_funct3, issue_offset, resp_valid, resp_data,
           chk_rs1, chk_rs2, chk_rd,
    input  issue_ready, stall, ra3, wd3, we3, pending
  );
  modport slave(
    input  issue_valid, issue_rd, issue_funct3, issue_offset, resp_valid, resp_data,
           chk_rs1, chk_rs2, chk_rd,
    output issue_ready, stall, ra3, wd3, we3, pending
  );
endinterface

// File: rtl/load_writeback_extend.sv
// load_extend: selects the addressed byte/halfword/word and sign- or zero-extends it
module load_extend
  import load_writeback_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       funct3_i,
  input  logic [1:0]       offset_i,
  input  logic [WIDTH-1:0] word_i,
  output logic [WIDTH-1:0] ext_o
);
  logic [7:0] byte_v;
  logic [15:0] half_v;
  always_comb begin
    byte_v = word_i[{offset_i, 3'b000} +: 8];
    half_v = offset_i[1] ? word_i[31:16] : word_i[15:0];
    ext_o  = funct3_i == FUNCT3_LB  ? {{(WIDTH-8){byte_v[7]}}, byte_v} :
             funct3_i == FUNCT3_LBU ? {{(WIDTH-8){1'b0}}, byte_v} :
             funct3_i == FUNCT3_LH  ? {{(WIDTH-16){half_v[15]}}, half_v} :
             funct3_i == FUNCT3_LHU ? {{(WIDTH-16){1'b0}}, half_v} :
             word_i;
  end
endmodule

// File: rtl/load_writeback.sv
// load_writeback: queues outstanding loads, extends in-order RAM data and drives the
// register-file load write port plus a RAW/WAW stall for the decode stage
module load_writeback
  import load_writeback_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input logic clk,
  input logic rst,
  load_writeback_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_WIDTH-1:0] rd_q [DEPTH];
  logic [2:0] f3_q [DEPTH];
  logic [1:0] off_q [DEPTH];
  logic [PW-1:0] wp_q, rp_q, age;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] ra3_q;
  logic [WIDTH-1:0] wd3_q, ext;
  logic we3_q, push, pop, stall_c;
  assign bus.issue_ready = cnt_q != CW'(DEPTH);
  assign push = bus.issue_valid && bus.issue_ready;
  assign pop = bus.resp_valid && cnt_q != '0;
  assign cnt_d = cnt_q + CW'(push) - CW'(pop);
  assign bus.pending = cnt_q;
  assign bus.we3 = we3_q;
  assign bus.ra3 = ra3_q;
  assign bus.wd3 = wd3_q;
  assign bus.stall = stall_c;
  load_extend #(.WIDTH(WIDTH)) u_ext (
    .funct3_i(f3_q[rp_q]),
    .offset_i(off_q[rp_q]),
    .word_i  (bus.resp_data),
    .ext_o   (ext)
  );
  // Entry i is live when its distance from the read pointer is below the count
  always_comb begin
    stall_c = 1'b0;
    age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age = PW'(i) - rp_q;
      stall_c = stall_c | ({1'b0, age} < cnt_q && rd_q[i] != '0 &&
                (rd_q[i] == bus.chk_rs1 || rd_q[i] == bus.chk_rs2 || rd_q[i] == bus.chk_rd));
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      we3_q <= 1'b0;
      ra3_q <= '0;
      wd3_q <= '0;
    end else begin
      wp_q <= push ? wp_q + PW'(1) : wp_q;
      rp_q <= pop ? rp_q + PW'(1) : rp_q;
      cnt_q <= cnt_d;
      we3_q <= pop;
      if (pop) begin
        ra3_q <= rd_q[rp_q];
        wd3_q <= ext;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wp_q] <= bus.issue_rd;
      f3_q[wp_q] <= bus.issue_funct3;
      off_q[wp_q] <= bus.issue_offset;
    end
  end
endmodule

// File: tb/tb_load_writeback.sv
// tb_load_writeback: table-driven extension vectors plus scoreboarded write-back sequences
module tb_load_writeback;
  import load_writeback_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  load_writeback_if #(.ADDR_WIDTH(5), .WIDTH(32), .DEPTH(2)) bus ();
  load_writeback #(.ADDR_WIDTH(5), .WIDTH(32), .DEPTH(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  logic [2:0] x_f3;
  logic [1:0] x_off;
  logic [31:0] x_word, x_ext;
  load_extend #(.WIDTH(32)) u_ext (
    .funct3_i(x_f3),
    .offset_i(x_off),
    .word_i  (x_word),
    .ext_o   (x_ext)
  );
  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
  } wb_t;
  vec_t vecs[12];
  wb_t sb[$];
  wb_t e;
  int checks = 0;
  int failures = 0;
  int wb_cnt = 0;
  int wb_start;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                       input logic [31:0] exp);
    bus.issue_valid = 1'b1;
    bus.issue_rd = rd;
    bus.issue_funct3 = f3;
    bus.issue_offset = off;
    sb.push_back('{rd, exp});
    tick();
    bus.issue_valid = 1'b0;
  endtask
  task automatic respond(input logic [31:0] data);
    bus.resp_valid = 1'b1;
    bus.resp_data = data;
    tick();
    bus.resp_valid = 1'b0;
  endtask
  always @(negedge clk) begin
    if (!rst && bus.we3) begin
      wb_cnt++;
      if (sb.size() == 0) chk("unexpected_we3", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("wb_ra3", 32'(bus.ra3), 32'(e.rd));
        chk("wb_wd3", bus.wd3, e.wd);
      end
    end
  end
  initial begin
    vecs[0]  = '{FUNCT3_LB,  2'd1, 32'h1234_80FF, 32'hFFFF_FF80};
    vecs[1]  = '{FUNCT3_LHU, 2'd2, 32'h8001_0000, 32'h0000_8001};
    vecs[2]  = '{FUNCT3_LH,  2'd2, 32'h8001_0000, 32'hFFFF_8001};
    vecs[3]  = '{FUNCT3_LW,  2'd3, 32'h8001_0000, 32'h8001_0000};
    vecs[4]  = '{FUNCT3_LBU, 2'd3, 32'h80FF_1234, 32'h0000_0080};
    vecs[5]  = '{FUNCT3_LB,  2'd0, 32'hFFFF_FF7F, 32'h0000_007F};
    vecs[6]  = '{FUNCT3_LH,  2'd1, 32'h1234_ABCD, 32'hFFFF_ABCD};
    vecs[7]  = '{FUNCT3_LHU, 2'd3, 32'hFEDC_0000, 32'h0000_FEDC};
    vecs[8]  = '{3'b011,     2'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[9]  = '{3'b110,     2'd2, 32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[10] = '{3'b111,     2'd0, 32'h0BAD_CAFE, 32'h0BAD_CAFE};
    vecs[11] = '{FUNCT3_LBU, 2'd2, 32'h00AB_0000, 32'h0000_00AB};
    bus.issue_valid = 1'b0;
    bus.issue_rd = '0;
    bus.issue_funct3 = '0;
    bus.issue_offset = '0;
    bus.resp_valid = 1'b0;
    bus.resp_data = '0;
    bus.chk_rs1 = '0;
    bus.chk_rs2 = '0;
    bus.chk_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pending", 32'(bus.pending), 32'd0);
    chk("rst_we3", 32'(bus.we3), 32'd0);
    chk("rst_ra3", 32'(bus.ra3), 32'd0);
    chk("rst_wd3", bus.wd3, 32'd0);
    chk("rst_ready", 32'(bus.issue_ready), 32'd1);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      x_f3 = vecs[i].f3;
      x_off = vecs[i].off;
      x_word = vecs[i].data;
      #1;
      chk($sformatf("ext_unit[%0d]", i), x_ext, vecs[i].exp);
    end
    for (int i = 0; i < 12; i++) begin
      issue(5'(i + 1), vecs[i].f3, vecs[i].off, vecs[i].exp);
      respond(vecs[i].data);
      tick();
    end
    issue(5'd4, FUNCT3_LW, 2'd0, 32'hAAAA_0004);
    issue(5'd6, FUNCT3_LW, 2'd0, 32'hBBBB_0006);
    chk("full_pending", 32'(bus.pending), 32'd2);
    chk("full_ready", 32'(bus.issue_ready), 32'd0);
    bus.chk_rs2 = 5'd6;
    #1 chk("stall_rs2", 32'(bus.stall), 32'd1);
    bus.chk_rs2 = 5'd0;
    bus.chk_rd = 5'd4;
    #1 chk("stall_rd", 32'(bus.stall), 32'd1);
    bus.chk_rd = 5'd0;
    bus.chk_rs1 = 5'd9;
    #1 chk("no_stall", 32'(bus.stall), 32'd0);
    bus.chk_rs1 = 5'd0;
    bus.chk_rd = 5'd4;
    bus.resp_valid = 1'b1;
    bus.resp_data = 32'hAAAA_0004;
    bus.issue_valid = 1'b1;
    bus.issue_rd = 5'd9;
    #1 chk("stall_popping", 32'(bus.stall), 32'd1);
    tick();
    bus.resp_valid = 1'b0;
    bus.issue_valid = 1'b0;
    chk("full_issue_ignored", 32'(bus.pending), 32'd1);
    chk("stall_after_pop", 32'(bus.stall), 32'd0);
    bus.chk_rd = 5'd6;
    respond(32'hBBBB_0006);
    chk("drain_pending", 32'(bus.pending), 32'd0);
    chk("inflight_no_stall", 32'(bus.stall), 32'd0);
    bus.chk_rd = 5'd0;
    tick();
    issue(5'd6, FUNCT3_LW, 2'd0, 32'h0000_0061);
    issue(5'd6, FUNCT3_LW, 2'd0, 32'h0000_0062);
    bus.chk_rs1 = 5'd6;
    respond(32'h0000_0061);
    chk("dup_stall_one_left", 32'(bus.stall), 32'd1);
    respond(32'h0000_0062);
    chk("dup_stall_cleared", 32'(bus.stall), 32'd0);
    bus.chk_rs1 = 5'd0;
    tick();
    issue(5'd0, FUNCT3_LW, 2'd0, 32'h1234_5678);
    #1 chk("x0_no_stall", 32'(bus.stall), 32'd0);
    respond(32'h1234_5678);
    tick();
    issue(5'd4, FUNCT3_LW, 2'd0, 32'h0);
    issue(5'd6, FUNCT3_LW, 2'd0, 32'h0);
    bus.chk_rs1 = 5'd4;
    #3;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("arst_pending", 32'(bus.pending), 32'd0);
    chk("arst_we3", 32'(bus.we3), 32'd0);
    chk("arst_stall", 32'(bus.stall), 32'd0);
    chk("arst_ready", 32'(bus.issue_ready), 32'd1);
    tick();
    rst = 1'b0;
    bus.chk_rs1 = 5'd0;
    respond(32'h5555_5555);
    chk("orphan_no_we3", 32'(bus.we3), 32'd0);
    chk("orphan_pending", 32'(bus.pending), 32'd0);
    tick();
    wb_start = wb_cnt;
    for (int k = 0; k <= 8; k++) begin
      bus.issue_valid = k < 8;
      bus.issue_rd = 5'(k + 1);
      bus.issue_funct3 = FUNCT3_LW;
      bus.issue_offset = 2'd0;
      if (k < 8) sb.push_back('{5'(k + 1), 32'hC0DE_0000 + 32'(k + 1)});
      bus.resp_valid = k > 0;
      bus.resp_data = 32'hC0DE_0000 + 32'(k);
      tick();
      chk($sformatf("b2b_pending[%0d]", k), 32'(bus.pending), (k < 8) ? 32'd1 : 32'd0);
    end
    bus.issue_valid = 1'b0;
    bus.resp_valid = 1'b0;
    tick();
    tick();
    chk("b2b_pulses", 32'(wb_cnt - wb_start), 32'd8);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
